// File: rtl/hit_pkg.sv
// Shared types for the player hit detector: hit source codes and FSM states,
// plus the helper that picks the qualification threshold.
package hit_pkg;

    typedef enum logic [1:0] {
        HIT_NONE     = 2'b00,
        HIT_MISSILE  = 2'b01,
        HIT_ASTEROID = 2'b10,
        HIT_BOTH     = 2'b11
    } hit_source_t;

    typedef enum logic {
        ACCUM  = 1'b0,
        REPORT = 1'b1
    } hit_state_t;

    // With filtering off, a single overlap pixel is enough to qualify a frame.
    function automatic int hit_threshold(input bit filter_en, input int min_overlap);
        return filter_en ? min_overlap : 1;
    endfunction

endpackage

// File: rtl/player_hit_detector_sat_counter.sv
// Saturating up-counter with synchronous clear that can load 0 or 1.
// Clear has priority over increment so a frame boundary can restart the count.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_load_one,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= WIDTH'(i_load_one);
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/player_hit_detector.sv
// Frame-level collision detector: counts player/missile/asteroid overlap pixels
// and emits at most one qualified hit pulse per frame. Optional macro: COLLISION_FILTER_EN.
module player_hit_detector
    import hit_pkg::*;
#(
    parameter int OVERLAP_WIDTH = 8,
    parameter int MIN_OVERLAP   = 4,
    parameter int HITS_WIDTH    = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  startOfFrame,
    input  logic                  player_draw_request,
    input  logic                  missile_draw_request,
    input  logic                  asteroid_draw_request,
    input  logic                  player_damaged,
    output logic                  missile_collision,
    output logic [1:0]            hit_source,
    output logic [HITS_WIDTH-1:0] total_hits,
    output hit_state_t            o_dbg_state
);

`ifdef COLLISION_FILTER_EN
    localparam bit FILTER_EN = 1'b1;
`else
    localparam bit FILTER_EN = 1'b0;
`endif

    localparam int                     THRESHOLD   = hit_threshold(FILTER_EN, MIN_OVERLAP);
    localparam logic [OVERLAP_WIDTH-1:0] THRESHOLD_V = OVERLAP_WIDTH'(THRESHOLD);

    hit_state_t         r_state;
    hit_state_t         w_state_next;
    hit_source_t        r_hit_source;
    logic               r_src_missile;
    logic               r_src_asteroid;
    logic               w_overlap;
    logic               w_qualify;
    logic [OVERLAP_WIDTH-1:0] w_overlap_cnt;

    assign w_overlap = player_draw_request && (missile_draw_request || asteroid_draw_request);

    // A coincident overlap pixel belongs to the new frame, so the counter reloads 1.
    sat_counter #(
        .WIDTH (OVERLAP_WIDTH)
    ) u_overlap_cnt (
        .clk        (clk),
        .reset      (reset),
        .i_clear    (startOfFrame),
        .i_load_one (w_overlap),
        .i_inc      (w_overlap),
        .o_count    (w_overlap_cnt)
    );

    sat_counter #(
        .WIDTH (HITS_WIDTH)
    ) u_total_hits (
        .clk        (clk),
        .reset      (reset),
        .i_clear    (1'b0),
        .i_load_one (1'b0),
        .i_inc      (w_qualify),
        .o_count    (total_hits)
    );

    always_comb begin
        w_state_next = r_state;
        w_qualify    = startOfFrame && (w_overlap_cnt >= THRESHOLD_V) && !player_damaged;
        case (r_state)
            ACCUM:   w_state_next = w_qualify ? REPORT : ACCUM;
            // A strobe landing in REPORT is evaluated normally, allowing back-to-back pulses.
            REPORT:  w_state_next = w_qualify ? REPORT : ACCUM;
            default: w_state_next = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_src_missile  <= 1'b0;
            r_src_asteroid <= 1'b0;
        end else if (startOfFrame) begin
            r_src_missile  <= w_overlap && missile_draw_request;
            r_src_asteroid <= w_overlap && asteroid_draw_request;
        end else if (w_overlap) begin
            r_src_missile  <= r_src_missile  | missile_draw_request;
            r_src_asteroid <= r_src_asteroid | asteroid_draw_request;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hit_source <= HIT_NONE;
        end else if (w_qualify) begin
            r_hit_source <= hit_source_t'({r_src_asteroid, r_src_missile});
        end
    end

    assign missile_collision = (r_state == REPORT);
    assign hit_source        = r_hit_source;
    assign o_dbg_state       = r_state;

endmodule

// File: tb/tb_player_hit_detector.sv
// Self-checking bench for player_hit_detector: directed frame scenarios followed by
// randomized pixel/strobe traffic, compared against a frame-level reference model.
module tb_player_hit_detector;
    import hit_pkg::*;

    localparam int OW  = 8;
    localparam int HW  = 8;
    localparam int MIN = 4;
`ifdef COLLISION_FILTER_EN
    localparam int THR = MIN;
`else
    localparam int THR = 1;
`endif
    localparam int HITS_MAX = (1 << HW) - 1;

    logic          clk;
    logic          reset;
    logic          startOfFrame;
    logic          player_draw_request;
    logic          missile_draw_request;
    logic          asteroid_draw_request;
    logic          player_damaged;
    logic          missile_collision;
    logic [1:0]    hit_source;
    logic [HW-1:0] total_hits;
    hit_state_t    o_dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: pixel sources seen this frame, last reported source, hit total.
    logic [1:0]    frame_px[$];
    logic [1:0]    m_src;
    int            m_hits;
    logic [10:0]   exp_q[$];

    player_hit_detector #(
        .OVERLAP_WIDTH (OW),
        .MIN_OVERLAP   (MIN),
        .HITS_WIDTH    (HW)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .startOfFrame          (startOfFrame),
        .player_draw_request   (player_draw_request),
        .missile_draw_request  (missile_draw_request),
        .asteroid_draw_request (asteroid_draw_request),
        .player_damaged        (player_damaged),
        .missile_collision     (missile_collision),
        .hit_source            (hit_source),
        .total_hits            (total_hits),
        .o_dbg_state           (o_dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drive one cycle, advance the model, then compare outputs just after the edge.
    task automatic step(input bit sof, input bit p, input bit m, input bit a,
                        input bit d, input bit r);
        bit         pulse;
        logic [1:0] src_or;
        logic [10:0] exp;
        reset                 = r;
        startOfFrame          = sof;
        player_draw_request   = p;
        missile_draw_request  = m;
        asteroid_draw_request = a;
        player_damaged        = d;
        pulse = 1'b0;
        if (r) begin
            frame_px.delete();
            m_src  = 2'b00;
            m_hits = 0;
        end else begin
            if (sof) begin
                if (frame_px.size() >= THR && !d) begin
                    pulse  = 1'b1;
                    src_or = 2'b00;
                    foreach (frame_px[i]) src_or |= frame_px[i];
                    m_src = src_or;
                    if (m_hits < HITS_MAX) m_hits++;
                end
                frame_px.delete();
            end
            if (p && (m || a)) frame_px.push_back({a, m});
        end
        exp_q.push_back({pulse, m_src, m_hits[HW-1:0]});
        @(posedge clk);
        #1;
        exp = exp_q.pop_front();
        check("missile_collision", 32'(missile_collision), 32'(exp[10]));
        check("hit_source", 32'(hit_source), 32'(exp[9:8]));
        check("total_hits", 32'(total_hits), 32'(exp[7:0]));
        check("dbg_state", 32'(o_dbg_state), exp[10] ? 32'(REPORT) : 32'(ACCUM));
    endtask

    task automatic px(input int n, input bit m, input bit a);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, m, a, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic strobe(input bit d);
        step(1'b1, 1'b0, 1'b0, 1'b0, d, 1'b0);
    endtask

    initial begin
        m_src  = 2'b00;
        m_hits = 0;
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(2);

        // Missile-only frame well above any threshold.
        px(5, 1'b1, 1'b0);
        strobe(1'b0);
        idle(2);

        // Short graze of 3 pixels: qualifies only without filtering.
        px(3, 1'b1, 1'b0);
        strobe(1'b0);
        idle(1);

        // Empty frame, and draws that never overlap the player.
        strobe(1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        strobe(1'b0);
        idle(1);

        // Asteroid-only, then mixed sources.
        px(4, 1'b0, 1'b1);
        strobe(1'b0);
        px(2, 1'b1, 1'b0);
        px(2, 1'b0, 1'b1);
        strobe(1'b0);
        idle(1);

        // Damaged player suppresses the hit, next frame has nothing.
        px(10, 1'b1, 1'b1);
        strobe(1'b1);
        strobe(1'b0);
        idle(1);

        // Coincident overlap and strobe, then 3 more pixels complete the next frame.
        px(4, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        px(3, 1'b0, 1'b1);
        strobe(1'b0);
        // Strobe in REPORT with a coincident pixel, then back-to-back strobes.
        px(4, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        strobe(1'b0);
        strobe(1'b0);
        idle(1);

        // Drive total_hits into saturation and keep going.
        while (m_hits < HITS_MAX) begin
            px(4, 1'b1, 1'b0);
            strobe(1'b0);
        end
        for (int k = 0; k < 3; k++) begin
            px(4, 1'b0, 1'b1);
            strobe(1'b0);
        end
        idle(1);

        // Reset mid-frame discards the partial frame.
        px(6, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        strobe(1'b0);
        idle(2);

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 9) == 0,
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 499) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/player_hit_detector.md
# player_hit_detector

Frame-level collision detector that produces the `missile_collision` pulse consumed by the player lives block. It watches per-pixel draw requests from the player, enemy missiles and asteroids, and counts overlap pixels during each frame. At the frame boundary it issues at most one qualified hit per frame, with a source code and a running hit counter. It sits between the drawing/object layer and the player lives logic.

## Interface
- `OVERLAP_WIDTH`, default 8: width of the per-frame overlap pixel counter.
- `MIN_OVERLAP`, default 4: overlap pixels required for a hit. Used only when filtering is compiled in.
- `HITS_WIDTH`, default 8: width of the `total_hits` counter.

Ports (`name direction width meaning`):
- `clk` input 1: single system clock.
- `reset` input 1: synchronous, active-high reset.
- `startOfFrame` input 1: one-cycle frame boundary strobe.
- `player_draw_request` input 1: the player is drawing the current pixel.
- `missile_draw_request` input 1: any enemy missile is drawing the current pixel.
- `asteroid_draw_request` input 1: any asteroid is drawing the current pixel.
- `player_damaged` input 1: from the lives block; while high, hits are suppressed.
- `missile_collision` output 1: one-cycle qualified hit pulse.
- `hit_source` output 2: source of the last reported hit. 00 none, 01 missile, 10 asteroid, 11 both.
- `total_hits` output `HITS_WIDTH`: saturating count of reported hits.

## Operation
- Two states: `ACCUM` and `REPORT`. Reset state is `ACCUM`.
- In `ACCUM`, each cycle the overlap condition is evaluated. Overlap is `player_draw_request && (missile_draw_request || asteroid_draw_request)`.
  - On overlap, `overlap_cnt` increments, saturating at 2^OVERLAP_WIDTH−1.
  - `src_missile` and/or `src_asteroid` flags are set accordingly.
- On `startOfFrame`, the frame qualifies if `overlap_cnt >= threshold` and `player_damaged == 0`.
  - `threshold` is `MIN_OVERLAP` with filtering compiled in, otherwise 1.
  - If the frame qualifies: go to `REPORT`, register `missile_collision <= 1`, set `hit_source` from the flags, and increment `total_hits` (saturating at all-ones).
  - Whether or not it qualifies: clear `overlap_cnt` and both flags.
- In `REPORT`, `missile_collision <= 0` and the state returns to `ACCUM`. Overlap pixels during this cycle are counted toward the new frame.
- `hit_source` holds its value until the next reported hit or reset.
- Reset values: `missile_collision` 0, `hit_source` 00, `total_hits` 0, `overlap_cnt` 0, flags 0, state `ACCUM`.

## Timing
- `missile_collision` is high for exactly the one cycle after the `startOfFrame` cycle. Latency is 1 clock from the strobe.
- At most one pulse per frame.
- `hit_source` and `total_hits` update on the same edge as the pulse rise.
- Overlap and `startOfFrame` in the same cycle: the frame evaluation uses the count before this cycle. The coincident pixel is counted into the new frame (counter loads 1 instead of 0).
- `startOfFrame` while in `REPORT`: the new frame is evaluated normally. Back-to-back pulses are legal and are separated by at least one low cycle only if the strobes are separated.
- `player_damaged` is sampled only on the `startOfFrame` cycle.
- `reset` mid-frame: all state is cleared on the next edge. A partially accumulated frame is discarded and no pulse is issued.

## Configuration
- `COLLISION_FILTER_EN`
  - Defined: a frame must accumulate ≥ `MIN_OVERLAP` overlap pixels to qualify. This rejects single-pixel grazes.
  - Undefined: any single overlap pixel qualifies, and `MIN_OVERLAP` is ignored.

## Structure
- Shared package `hit_pkg` holds:
  - the `hit_source_t` 2-bit enum (`HIT_NONE`, `HIT_MISSILE`, `HIT_ASTEROID`, `HIT_BOTH`);
  - the state enum `hit_state_t` (`ACCUM`, `REPORT`).
- One sub-module, `sat_counter`: a parameterised-width saturating counter with sync clear/load-one. It is instantiated for `overlap_cnt` and for `total_hits`.
- FSM and source flags stay in the top module.

## Test plan
- Filter on, `MIN_OVERLAP`=4: 5 overlap pixels of missile in frame, then `startOfFrame` → one-cycle `missile_collision` on the next cycle, `hit_source`=01, `total_hits`=1.
- Filter on: 3 overlap pixels, then strobe → no pulse, `total_hits` stays 0. Filter off, 1 pixel → pulse.
- Missile and asteroid overlaps in the same frame (≥ threshold) → `hit_source`=11, single pulse.
- 10 qualifying pixels with `player_damaged`=1 at strobe → no pulse, counter cleared. Next frame with `player_damaged`=0 and 0 overlaps → no pulse.
- Overlap pixel coincident with `startOfFrame` after 4 prior pixels → pulse for the old frame. New frame count starts at 1, so 3 more pixels qualify the next frame.
- `total_hits` at 255 plus a qualifying frame → stays 255 and the pulse still fires. `reset` asserted mid-frame after 6 pixels → outputs zero, no pulse at the next strobe.
